// File: rtl/sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_if
// Description : Request/response bus between a client and sram_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_ctrl_if;
    logic        i_req_vld;
    logic        o_req_rdy;
    logic        i_req_we;
    logic [16:0] i_req_addr;
    logic [3:0]  i_req_bmask;
    logic [31:0] i_req_wdata;
    logic        o_rsp_vld;
    logic [31:0] o_rsp_rdata;

    modport master (
        output i_req_vld, i_req_we, i_req_addr, i_req_bmask, i_req_wdata,
        input  o_req_rdy, o_rsp_vld, o_rsp_rdata
    );

    modport slave (
        input  i_req_vld, i_req_we, i_req_addr, i_req_bmask, i_req_wdata,
        output o_req_rdy, o_rsp_vld, o_rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : 32-bit word access to a 16-bit asynchronous SRAM as two
//               halfword phases (LO then HI), little-endian.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic        i_clk,
    input  wire logic        i_rstn,
    sram_ctrl_if.slave       bus,
    output logic [17:0]      o_sram_addr,
    inout  wire  [15:0]      io_sram_dq,
    output logic             o_sram_ce_n,
    output logic             o_sram_we_n,
    output logic             o_sram_oe_n,
    output logic             o_sram_lb_n,
    output logic             o_sram_ub_n
);
    localparam logic [2:0] C_WAIT = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic        r_we;
    logic [16:0] r_addr;
    logic [3:0]  r_bmask;
    logic [31:0] r_wdata;
    logic [15:0] r_rdata_lo;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_phase;
    logic        w_phase_end;
    logic        w_is_hi;
    logic        w_dq_en;
    logic [15:0] w_dq_out;

    assign w_accept    = (r_state == S_IDLE) && bus.i_req_vld;
    assign w_phase     = (r_state == S_LO) || (r_state == S_HI);
    assign w_phase_end = w_phase && (r_cnt == C_WAIT);
    assign w_is_hi     = (r_state == S_HI);

    // Only write phases drive the bus; oe_n is low only in read phases.
    assign io_sram_dq      = w_dq_en ? w_dq_out : 16'bz;
    assign bus.o_rsp_rdata = r_rdata;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_we       <= 1'b0;
            r_addr     <= 17'd0;
            r_bmask    <= 4'd0;
            r_wdata    <= 32'd0;
            r_rdata_lo <= 16'd0;
            r_rdata    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we    <= bus.i_req_we;
                r_addr  <= bus.i_req_addr;
                r_bmask <= bus.i_req_bmask;
                r_wdata <= bus.i_req_wdata;
            end
            r_cnt <= (w_phase && (r_cnt != C_WAIT)) ? r_cnt + 3'd1 : 3'd0;
            if (w_phase_end && !r_we) begin
                if (w_is_hi)
                    r_rdata <= {io_sram_dq, r_rdata_lo};
                else
                    r_rdata_lo <= io_sram_dq;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.o_req_rdy = 1'b0;
        bus.o_rsp_vld = 1'b0;
        o_sram_addr   = 18'd0;
        o_sram_ce_n   = 1'b1;
        o_sram_we_n   = 1'b1;
        o_sram_oe_n   = 1'b1;
        o_sram_lb_n   = 1'b1;
        o_sram_ub_n   = 1'b1;
        w_dq_en       = 1'b0;
        w_dq_out      = 16'd0;

        case (r_state)
            S_IDLE: begin
                bus.o_req_rdy = 1'b1;
                if (bus.i_req_vld) begin
                    // Writes skip halves whose byte enables are all zero.
                    if (!bus.i_req_we || (|bus.i_req_bmask[1:0]))
                        w_state_nxt = S_LO;
                    else if (|bus.i_req_bmask[3:2])
                        w_state_nxt = S_HI;
                    else
                        w_state_nxt = S_RESP;
                end
            end
            S_LO: begin
                if (r_cnt == C_WAIT)
                    w_state_nxt = (!r_we || (|r_bmask[3:2])) ? S_HI : S_RESP;
            end
            S_HI: begin
                if (r_cnt == C_WAIT)
                    w_state_nxt = S_RESP;
            end
            S_RESP: begin
                bus.o_rsp_vld = 1'b1;
                w_state_nxt   = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_phase) begin
            o_sram_ce_n = 1'b0;
            o_sram_addr = {r_addr, w_is_hi};
            if (r_we) begin
                // Last cycle of the phase is the hold cycle with we_n high.
                w_dq_en     = 1'b1;
                w_dq_out    = w_is_hi ? r_wdata[31:16] : r_wdata[15:0];
                o_sram_we_n = (r_cnt == C_WAIT);
                o_sram_lb_n = w_is_hi ? ~r_bmask[2] : ~r_bmask[0];
                o_sram_ub_n = w_is_hi ? ~r_bmask[3] : ~r_bmask[1];
            end else begin
                o_sram_oe_n = 1'b0;
                o_sram_lb_n = 1'b0;
                o_sram_ub_n = 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, number of cycles (1..7) that we_n is held low per halfword phase; each phase lasts WAIT_CYCLES+1 cycles.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, with the following ports (clock and reset first):
- i_clk  in  1  clock
- i_rstn  in  1  async active-low reset
- i_req_vld  in  1  request valid
- o_req_rdy  out  1  ready; high only in IDLE
- i_req_we  in  1  1=write, 0=read
- i_req_addr  in  17  32-bit word address
- i_req_bmask  in  4  byte enables; bit n = data[8n+7:8n]
- i_req_wdata  in  32  write data
- o_rsp_vld  out  1  one-cycle completion pulse
- o_rsp_rdata  out  32  read data
- o_sram_addr  out  18  SRAM halfword address
- io_sram_dq  inout  16  SRAM data bus
- o_sram_ce_n  out  1  chip enable, active low
- o_sram_we_n  out  1  write enable, active low
- o_sram_oe_n  out  1  output enable, active low
- o_sram_lb_n  out  1  lower byte enable, active low
- o_sram_ub_n  out  1  upper byte enable, active low

Function
REQ-003 States SHALL be IDLE, LO, HI and RESP; a request is accepted on a rising edge where i_req_vld=1 and o_req_rdy=1, and all request fields are captured at that edge.
REQ-004 Data order SHALL be little-endian: the LO phase uses address {addr,0} with data[15:0] and bmask[1:0]; the HI phase uses {addr,1} with data[31:16] and bmask[3:2].
REQ-005 A read SHALL always execute LO then HI, with lb_n=ub_n=0, oe_n=0 and we_n=1 in both phases.
REQ-006 On a read, dq SHALL be sampled on the final edge of each phase, and o_rsp_rdata SHALL update on entry to RESP and hold until the next read completes.
REQ-007 On a write, a phase whose two bmask bits are both 0 SHALL be skipped; lb_n/ub_n SHALL equal the inverted bmask bits; oe_n=1.
REQ-008 On a write, dq SHALL be driven for the whole phase, we_n SHALL be low for the first WAIT_CYCLES cycles of the phase and high in the last cycle, and address and data SHALL stay stable through that last (hold) cycle.
REQ-009 In LO and HI, o_sram_ce_n SHALL be 0; consecutive LO and HI phases SHALL be back-to-back with no idle cycle between them.
REQ-010 In IDLE and RESP, the SRAM outputs SHALL be: ce_n=we_n=oe_n=lb_n=ub_n=1, addr=0, dq high-Z.
REQ-011 dq SHALL be driven only during write phases and SHALL never be driven while oe_n=0.
REQ-012 RESP SHALL last exactly 1 cycle with o_rsp_vld=1, then return to IDLE; o_req_rdy SHALL be 0 in RESP.
REQ-013 Latency from the accept edge to the o_rsp_vld cycle SHALL be: read = 2*(WAIT_CYCLES+1)+1; write = k*(WAIT_CYCLES+1)+1, where k is the number of active halves (0..2).
REQ-014 A write with bmask=0000 SHALL go IDLE->RESP with no SRAM activity.
REQ-015 Requests presented while o_req_rdy=0 SHALL be ignored, not queued.
REQ-016 A new request SHALL be acceptable in the cycle immediately after RESP.
REQ-017 o_rsp_rdata SHALL be unchanged by writes.

Reset
REQ-018 While i_rstn=0, asynchronously: state=IDLE, o_req_rdy=1, o_rsp_vld=0, o_rsp_rdata=0, and all SRAM outputs at the REQ-010 idle values.
REQ-019 Reset asserted mid-transaction SHALL abort the transaction: dq is released immediately, no o_rsp_vld is issued, and the SRAM content of any partially written halfword is undefined.
REQ-020 After reset deassertion, the first request SHALL be acceptable on the first rising edge.

Verification (WAIT_CYCLES=1, bench SRAM model attached)
REQ-021 Write addr=0x00010, wdata=0xDEADBEEF, bmask=1111 -> LO: addr=0x00020, dq=0xBEEF, we_n low 1 cycle; HI: addr=0x00021, dq=0xDEAD; o_rsp_vld 5 cycles after accept.
REQ-022 Read addr=0x00010 after REQ-021 -> oe_n=0 for 4 cycles, o_rsp_rdata=0xDEADBEEF with o_rsp_vld 5 cycles after accept.
REQ-023 Write addr=0x00010, wdata=0x00AA0000, bmask=0100 -> HI phase only, lb_n=0, ub_n=1, o_rsp_vld 3 cycles after accept; read back gives 0xDEAABEEF.
REQ-024 Write with bmask=0000 -> o_rsp_vld 1 cycle after accept; ce_n stays 1 throughout.
REQ-025 i_req_vld held high for two back-to-back reads -> second accepted the cycle after the first RESP; o_req_rdy=0 during LO/HI/RESP.
REQ-026 Deassert i_rstn during the HI phase of a write -> ce_n=we_n=1 and dq high-Z with no clock edge, no o_rsp_vld; o_req_rdy=1 after release.
